// File: rtl/rel_phase_4steps_sched.sv
// Joins four pixel streams into aligned beats for the 4-step phase datapath; optional stall statistic under REL_PHASE_SCHED_STATS_EN.
// Latency: 1 cycle input to vld_o, done_o PIPE_LAT+2 cycles after the last beat; sources stall together while any is invalid or credit is 0.
module rel_phase_4steps_sched #(
    parameter int IMG_W      = 1280,
    parameter int IMG_H      = 1024,
    parameter int PIPE_LAT   = 24,
    parameter int FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    input  logic [3:0]  s_tvalid_i,
    output logic [3:0]  s_tready_o,
    input  logic [31:0] s_tdata_i,
    input  logic [3:0]  s_tlast_i,
    input  logic        fifo_pop_i,
    output logic        vld_o,
    output logic [7:0]  pixel1_o,
    output logic [7:0]  pixel2_o,
    output logic [7:0]  pixel3_o,
    output logic [7:0]  pixel4_o,
    output logic        tlast_o,
    output logic [31:0] stall_cnt_o
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
    localparam int KW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_LAT);
    localparam logic [KW-1:0] CREDIT_MAX = KW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_fire;
    logic            w_start_acc;
    logic            w_busy;
    logic            w_done;
    logic            w_col_last;
    logic            w_row_last;
    logic            w_frame_end;

    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [DW-1:0]   r_drain;
    logic [KW-1:0]   r_credit;
    logic            r_err;
    logic            r_vld;
    logic            r_tlast;
    logic [31:0]     r_pix;

    assign w_col_last  = (r_col == COL_LAST);
    assign w_row_last  = (r_row == ROW_LAST);
    assign w_frame_end = w_fire && w_col_last && w_row_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // No beat is consumed while reset is asserted, so nothing is lost upstream.
    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        w_start_acc = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_fire = rst_n && (&s_tvalid_i) && (r_credit != '0);
                if (w_fire && w_col_last && w_row_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (r_drain == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_start_acc) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_fire) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drain <= '0;
        end else if (w_frame_end) begin
            r_drain <= DRAIN_INIT;
        end else if ((r_state == S_DRAIN) && (r_drain != '0)) begin
            r_drain <= r_drain - DW'(1);
        end
    end

    // Credits mirror free downstream FIFO entries; pops beyond the depth are spurious.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_credit <= CREDIT_MAX;
        end else begin
            case ({w_fire, fifo_pop_i})
                2'b10:   r_credit <= r_credit - KW'(1);
                2'b01:   r_credit <= (r_credit == CREDIT_MAX) ? r_credit : r_credit + KW'(1);
                default: r_credit <= r_credit;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld   <= 1'b0;
            r_tlast <= 1'b0;
            r_pix   <= '0;
        end else begin
            r_vld   <= w_fire;
            r_tlast <= w_fire && w_col_last;
            if (w_fire) begin
                r_pix <= s_tdata_i;
            end
        end
    end

    // Source tlast is only cross-checked; the local counters decide line boundaries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_err <= 1'b0;
        end else if (w_fire && (s_tlast_i != {4{w_col_last}})) begin
            r_err <= 1'b1;
        end
    end

`ifdef REL_PHASE_SCHED_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_RUN) && !w_fire) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = 32'd0;
`endif

    assign s_tready_o = {4{w_fire}};
    assign busy_o     = w_busy;
    assign done_o     = w_done;
    assign err_o      = r_err;
    assign vld_o      = r_vld;
    assign tlast_o    = r_tlast;
    assign pixel1_o   = r_pix[7:0];
    assign pixel2_o   = r_pix[15:8];
    assign pixel3_o   = r_pix[23:16];
    assign pixel4_o   = r_pix[31:24];

endmodule
